uart_rx_mmio: RTL and testbench

//  - Memory-mapped UART receiver (8N1) with RX FIFO at 0x1001_3000.
//  - Feeds the boot ROM loader, which polls STATUS bit2 (rx_valid), reads DATA and copies bytes into RAM.
//  - Serial rxd -> 2-FF sync -> bit-timing FSM -> byte FIFO -> 32-bit bus read port.

---
 rtl/uart_rx_mmio_if.sv | 25 ++
 rtl/uart_rx_mmio.sv | 199 +++++++++++++++++++
 tb/tb_uart_rx_mmio.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/uart_rx_mmio_if.sv
// Register-window bus between a polling master (boot ROM loader) and the UART receiver.
// ren and wen are one-cycle strobes with no back-pressure; rdata is valid the cycle after ren and holds until the next ren.
interface uart_rx_mmio_if;
    logic [31:0] addr;
    logic        ren;
    logic        wen;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output addr,
        output ren,
        output wen,
        output wdata,
        input  rdata
    );

    modport slave (
        input  addr,
        input  ren,
        input  wen,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/uart_rx_mmio.sv
// 8N1 UART receiver with a byte FIFO behind a two-word register window (DATA, STATUS).
// The receive FSM state is exported on fsm_state (0 IDLE, 1 START, 2 DATA, 3 STOP).
module uart_rx_mmio #(
    parameter logic [31:0] BASE_ADDR    = 32'h1001_3000,
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           rxd,
    uart_rx_mmio_if.slave  bus,
    output logic [1:0]     fsm_state
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    localparam logic [31:0] DATA_ADDR   = BASE_ADDR;
    localparam logic [31:0] STATUS_ADDR = BASE_ADDR + 32'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    // Synchroniser flops reset high so a quiet line never looks like a start bit.
    logic rx_meta;
    logic rx_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rx_s    <= rx_meta;
        end
    end

    rx_state_e         state;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift;
    logic              push_valid;
    logic [7:0]        push_byte;
    logic              frame_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            push_valid <= 1'b0;
            push_byte  <= '0;
            frame_set  <= 1'b0;
        end else begin
            push_valid <= 1'b0;
            frame_set  <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    // Mid-start-bit check rejects glitches shorter than half a bit.
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        shift <= {rx_s, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                        if (rx_s) begin
                            push_valid <= 1'b1;
                            push_byte  <= shift;
                        end else begin
                            frame_set <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign fsm_state = state;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             overrun;
    logic             frame_err;

    logic fifo_full;
    logic fifo_empty;
    logic do_pop;
    logic do_push;
    logic overrun_set;
    logic clr_overrun;
    logic clr_frame;

    assign fifo_full  = (count == DEPTH_CNT);
    assign fifo_empty = (count == '0);

    assign do_pop      = bus.ren && (bus.addr == DATA_ADDR) && !fifo_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_push     = push_valid && (!fifo_full || do_pop);
    assign overrun_set = push_valid && fifo_full && !do_pop;

    assign clr_overrun = bus.wen && (bus.addr == STATUS_ADDR) && bus.wdata[1];
    assign clr_frame   = bus.wen && (bus.addr == STATUS_ADDR) && bus.wdata[3];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_byte;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Setting wins over a same-cycle write-1-to-clear.
            overrun   <= overrun_set | (overrun & ~clr_overrun);
            frame_err <= frame_set | (frame_err & ~clr_frame);
        end
    end

    logic [31:0] status_word;
    logic [31:0] data_word;

    assign status_word = {28'd0, frame_err, !fifo_empty, overrun, fifo_full};
    assign data_word   = fifo_empty ? 32'd0 : {24'd0, mem[rd_ptr]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rdata <= '0;
        end else if (bus.ren) begin
            case (bus.addr)
                DATA_ADDR:   bus.rdata <= data_word;
                STATUS_ADDR: bus.rdata <= status_word;
                default:     bus.rdata <= '0;
            endcase
        end
    end

    logic unused_wdata;
    assign unused_wdata = ^{bus.wdata[31:4], bus.wdata[2], bus.wdata[0]};

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Directed bench for uart_rx_mmio: serial frames in, register reads checked against hand-computed values.
module tb_uart_rx_mmio;

    localparam int          CPB  = 16;
    localparam logic [31:0] BASE = 32'h1001_3000;

    logic clk;
    logic rst_n;
    logic rxd;
    logic [1:0] fsm_state;

    int checks = 0;
    int errors = 0;

    uart_rx_mmio_if bus_if ();

    uart_rx_mmio #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rxd       (rxd),
        .bus       (bus_if.slave),
        .fsm_state (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        bus_if.addr = a;
        bus_if.ren  = 1'b1;
        step(1);
        bus_if.ren  = 1'b0;
        d = bus_if.rdata;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus_if.addr  = a;
        bus_if.wdata = d;
        bus_if.wen   = 1'b1;
        step(1);
        bus_if.wen   = 1'b0;
        bus_if.wdata = '0;
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        step(CPB);
    endtask

    task automatic send_byte(input logic [7:0] data, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            send_bit(data[i]);
        end
        send_bit(stop);
        rxd = 1'b1;
    endtask

    logic [31:0] rd;

    initial begin
        rst_n        = 1'b0;
        rxd          = 1'b1;
        bus_if.addr  = '0;
        bus_if.ren   = 1'b0;
        bus_if.wen   = 1'b0;
        bus_if.wdata = '0;
        step(3);
        check("reset_rdata", bus_if.rdata, 32'h0);
        check("reset_state", {30'd0, fsm_state}, 32'h0);
        rst_n = 1'b1;
        step(3);

        // 1: empty reads
        bus_read(BASE, rd);
        check("empty_data", rd, 32'h0);
        bus_read(BASE + 32'd4, rd);
        check("empty_status", rd, 32'h0);
        bus_read(BASE + 32'd8, rd);
        check("other_addr", rd, 32'h0);

        // 2: single good byte
        send_byte(8'hA5, 1'b1);
        step(4);
        bus_read(BASE + 32'd4, rd);
        check("a5_status", rd, 32'h4);
        bus_read(BASE, rd);
        check("a5_data", rd, 32'h0000_00A5);
        step(2);
        check("rdata_hold", bus_if.rdata, 32'h0000_00A5);
        bus_read(BASE + 32'd4, rd);
        check("a5_status_after", rd, 32'h0);

        // 3: short glitch is rejected
        rxd = 1'b0;
        step(4);
        rxd = 1'b1;
        step(20);
        check("glitch_state", {30'd0, fsm_state}, 32'h0);
        bus_read(BASE + 32'd4, rd);
        check("glitch_status", rd, 32'h0);

        // 4: framing error, then W1C
        send_byte(8'h3C, 1'b0);
        rxd = 1'b1;
        step(20);
        bus_read(BASE + 32'd4, rd);
        check("frame_status", rd, 32'h8);
        bus_read(BASE, rd);
        check("frame_nodata", rd, 32'h0);
        bus_write(BASE, 32'hFFFF_FFFF);
        bus_read(BASE + 32'd4, rd);
        check("frame_ignored_wr", rd, 32'h8);
        bus_write(BASE + 32'd4, 32'h8);
        bus_read(BASE + 32'd4, rd);
        check("frame_cleared", rd, 32'h0);

        // 5: overflow with nine bytes
        for (int b = 0; b < 9; b++) begin
            send_byte(8'(b), 1'b1);
        end
        step(4);
        bus_read(BASE + 32'd4, rd);
        check("ovf_status", rd, 32'h7);
        for (int b = 0; b < 8; b++) begin
            bus_read(BASE, rd);
            check($sformatf("ovf_data%0d", b), rd, 32'(b));
        end
        bus_read(BASE + 32'd4, rd);
        check("ovf_status_after", rd, 32'h2);
        bus_write(BASE + 32'd4, 32'h2);
        bus_read(BASE + 32'd4, rd);
        check("ovf_cleared", rd, 32'h0);

        // 6: reset in the middle of 0x55
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        rst_n = 1'b0;
        step(2);
        check("midreset_state", {30'd0, fsm_state}, 32'h0);
        rxd = 1'b1;
        step(2);
        rst_n = 1'b1;
        step(4);
        send_byte(8'h81, 1'b1);
        step(4);
        bus_read(BASE + 32'd4, rd);
        check("midreset_status", rd, 32'h4);
        bus_read(BASE, rd);
        check("midreset_data", rd, 32'h0000_0081);
        bus_read(BASE + 32'd4, rd);
        check("midreset_empty", rd, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
